// File: rtl/keypad_emulator.sv
// ==== keypad_emulator: 4x4 keypad responder that drives rows for one queued key press (rev 1.0)
// ==== Optional contact-bounce phases compiled in with `define KEYPAD_EMU_BOUNCE_EN
`default_nettype none

module keypad_emulator #(
  parameter int HOLD_WIDTH     = 20,
  parameter int BOUNCE_PERIOD  = 1000,
  parameter int BOUNCE_TOGGLES = 6,
  parameter int GAP_CYCLES     = 2000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            keypad_vert,
  output logic [3:0]            keypad_hori,
  input  logic                  cmd_valid,
  input  logic [3:0]            cmd_key,
  input  logic [HOLD_WIDTH-1:0] cmd_hold,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  contact,
  output logic                  done
);

  localparam int c_bounce_len = BOUNCE_TOGGLES * BOUNCE_PERIOD;
  localparam int c_w_b        = $clog2(c_bounce_len + 1);
  localparam int c_w_g        = $clog2(GAP_CYCLES + 1);
  localparam int c_cnt_w      = (HOLD_WIDTH > c_w_b) ?
                                ((HOLD_WIDTH > c_w_g) ? HOLD_WIDTH : c_w_g) :
                                ((c_w_b > c_w_g) ? c_w_b : c_w_g);

  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic               c_gap_one  = (GAP_CYCLES == 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int                 c_tick_w      = $clog2(BOUNCE_PERIOD + 1);
  localparam logic [c_tick_w-1:0] c_tick_last  = c_tick_w'(BOUNCE_PERIOD - 1);
  localparam logic [c_cnt_w-1:0] c_bounce_last = c_cnt_w'(c_bounce_len - 1);
  localparam logic               c_bounce_skip = (BOUNCE_TOGGLES == 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BIN  = 3'd1,
    S_HOLD = 3'd2,
    S_BOUT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [1:0]           r_row;
  logic [1:0]           r_col;
  logic                 r_contact;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic [3:0]           r_hori;
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [c_tick_w-1:0]  r_tick;
  logic [HOLD_WIDTH-1:0] r_hold;
`endif

  logic [3:0]            w_pos;
  logic [HOLD_WIDTH-1:0] w_hold_eff;

  // Position encoded as {row, col} following the physical keypad legend.
  function automatic logic [3:0] key_pos(input logic [3:0] k);
    logic [3:0] p;
    case (k)
      4'h1: p = 4'b00_00;
      4'h2: p = 4'b00_01;
      4'h3: p = 4'b00_10;
      4'hA: p = 4'b00_11;
      4'h4: p = 4'b01_00;
      4'h5: p = 4'b01_01;
      4'h6: p = 4'b01_10;
      4'hB: p = 4'b01_11;
      4'h7: p = 4'b10_00;
      4'h8: p = 4'b10_01;
      4'h9: p = 4'b10_10;
      4'hC: p = 4'b10_11;
      4'hE: p = 4'b11_00;
      4'h0: p = 4'b11_01;
      4'hF: p = 4'b11_10;
      default: p = 4'b11_11;
    endcase
    return p;
  endfunction

  assign w_pos      = key_pos(cmd_key);
  assign w_hold_eff = (cmd_hold == '0) ? HOLD_WIDTH'(1) : cmd_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_row     <= 2'd0;
      r_col     <= 2'd0;
      r_contact <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      r_tick    <= '0;
      r_hold    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (cmd_valid && r_ready) begin
            r_ready        <= 1'b0;
            r_busy         <= 1'b1;
            r_contact      <= 1'b1;
            {r_row, r_col} <= w_pos;
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_hold <= w_hold_eff;
            r_tick <= c_tick_last;
            if (c_bounce_skip) begin
              r_state <= S_HOLD;
              r_cnt   <= c_cnt_w'(w_hold_eff - 1'b1);
            end else begin
              r_state <= S_BIN;
              r_cnt   <= c_bounce_last;
            end
`else
            r_state <= S_HOLD;
            r_cnt   <= c_cnt_w'(w_hold_eff - 1'b1);
`endif
          end
        end

`ifdef KEYPAD_EMU_BOUNCE_EN
        S_BIN: begin
          if (r_cnt == '0) begin
            r_state   <= S_HOLD;
            r_cnt     <= c_cnt_w'(r_hold - 1'b1);
            r_contact <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_tick == '0) begin
              r_tick    <= c_tick_last;
              r_contact <= ~r_contact;
            end else begin
              r_tick <= r_tick - 1'b1;
            end
          end
        end
`endif

        S_HOLD: begin
          if (r_cnt == '0) begin
            r_contact <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (c_bounce_skip) begin
              r_state <= S_GAP;
              r_cnt   <= c_gap_last;
              r_done  <= c_gap_one;
            end else begin
              r_state <= S_BOUT;
              r_cnt   <= c_bounce_last;
              r_tick  <= c_tick_last;
            end
`else
            r_state <= S_GAP;
            r_cnt   <= c_gap_last;
            r_done  <= c_gap_one;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

`ifdef KEYPAD_EMU_BOUNCE_EN
        S_BOUT: begin
          if (r_cnt == '0) begin
            r_state   <= S_GAP;
            r_cnt     <= c_gap_last;
            r_contact <= 1'b0;
            r_done    <= c_gap_one;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_tick == '0) begin
              r_tick    <= c_tick_last;
              r_contact <= ~r_contact;
            end else begin
              r_tick <= r_tick - 1'b1;
            end
          end
        end
`endif

        S_GAP: begin
          // done is raised one edge early so it coincides with the final gap cycle.
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == c_cnt_w'(1));
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_contact <= 1'b0;
          r_busy    <= 1'b0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hori <= 4'hF;
    end else begin
      r_hori <= 4'hF;
      if (r_contact && !keypad_vert[r_col]) begin
        r_hori[r_row] <= 1'b0;
      end
    end
  end

  assign keypad_hori = r_hori;
  assign cmd_ready   = r_ready;
  assign busy        = r_busy;
  assign contact     = r_contact;
  assign done        = r_done;

endmodule

`default_nettype wire
